// File: rtl/hex_pkg.sv
// Shared seven-segment pattern constants (active-low, bit 7 = dp) and
// the frame-reader FSM state type.
package hex_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Two BCD digits (each 0..9) to binary; the result never exceeds 99.
  function automatic logic [6:0] bcd2_to_bin(input logic [3:0] tens, input logic [3:0] ones);
    logic [6:0] t;
    t = {3'b000, tens};
    return (t << 3) + (t << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
// Active-low segment pattern back to a BCD digit; blank and illegal
// patterns report digit 0.
module seg_digit_decode
  import hex_pkg::*;
(
  input  logic [7:0] pat,
  output logic [3:0] digit,
  output logic       blank,
  output logic       illegal
);

  // Exact 8-bit match, so a lit dp makes the pattern illegal.
  always_comb begin
    digit   = 4'd0;
    blank   = 1'b0;
    illegal = 1'b0;
    case (pat)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/hex_frame_reader.sv
// Samples six HEX buses, waits for a stable frame, decodes it into three
// two-digit fields and offers each new frame over valid/ready.
module hex_frame_reader
  import hex_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int CW         = 8
) (
  input  logic       CK50M,
  input  logic       RST_N,
  input  logic [7:0] fr_HEX0,
  input  logic [7:0] fr_HEX1,
  input  logic [7:0] fr_HEX2,
  input  logic [7:0] fr_HEX3,
  input  logic [7:0] fr_HEX4,
  input  logic [7:0] fr_HEX5,
  input  logic       fr_ready,
  output logic       to_valid,
  output logic [6:0] to_val0,
  output logic [6:0] to_val1,
  output logic [6:0] to_val2,
  output logic       to_blank,
  output logic       to_err,
  output logic       to_ovf
);

  logic [47:0] hex_in_s, snap_r, last_r;
  logic [CW-1:0] cnt_r;
  logic          have_last_r, cand_s, load_s, drop_s;
  state_t        state_r, next_state_s;
  logic [3:0]    digit_s [6];
  logic [5:0]    blank_s, illegal_s;
  logic          all_blank_s, err_s;
  logic          valid_r, blank_r, err_r, ovf_r;
  logic [6:0]    val0_r, val1_r, val2_r;

  assign hex_in_s = {fr_HEX5, fr_HEX4, fr_HEX3, fr_HEX2, fr_HEX1, fr_HEX0};

  for (genvar g = 0; g < 6; g++) begin : g_dec
    seg_digit_decode u_dec (
      .pat     (snap_r[8*g +: 8]),
      .digit   (digit_s[g]),
      .blank   (blank_s[g]),
      .illegal (illegal_s[g])
    );
  end

  assign all_blank_s = &blank_s;
  assign err_s       = !all_blank_s && (|(blank_s | illegal_s));

  // Input snapshot and saturating stability counter; the counter restarts
  // whenever the incoming sample differs from the snapshot it replaces.
  always_ff @(posedge CK50M or negedge RST_N) begin
    if (!RST_N) begin
      snap_r <= 48'hFFFF_FFFF_FFFF;
      cnt_r  <= {CW{1'b0}};
    end else begin
      snap_r <= hex_in_s;
      if (hex_in_s != snap_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r != CW'(STABLE_CYC)) begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign cand_s = (cnt_r == CW'(STABLE_CYC - 1)) && (!have_last_r || (snap_r != last_r));

  // FSM state register.
  always_ff @(posedge CK50M or negedge RST_N) begin
    if (!RST_N) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // FSM next state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cand_s) next_state_s = ST_HOLD;
        else        next_state_s = ST_IDLE;
      end
      ST_HOLD: begin
        if (fr_ready && !cand_s) next_state_s = ST_IDLE;
        else                     next_state_s = ST_HOLD;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM actions: a held frame blocks new candidates unless it is being taken.
  always_comb begin
    load_s = 1'b0;
    drop_s = 1'b0;
    case (state_r)
      ST_IDLE: load_s = cand_s;
      ST_HOLD: begin
        if (cand_s) begin
          load_s = fr_ready;
          drop_s = !fr_ready;
        end else begin
          load_s = 1'b0;
          drop_s = 1'b0;
        end
      end
      default: begin
        load_s = 1'b0;
        drop_s = 1'b0;
      end
    endcase
  end

  // Output and last-frame registers.
  always_ff @(posedge CK50M or negedge RST_N) begin
    if (!RST_N) begin
      valid_r     <= 1'b0;
      val0_r      <= 7'd0;
      val1_r      <= 7'd0;
      val2_r      <= 7'd0;
      blank_r     <= 1'b0;
      err_r       <= 1'b0;
      ovf_r       <= 1'b0;
      have_last_r <= 1'b0;
      last_r      <= 48'h0;
    end else begin
      valid_r <= (next_state_s == ST_HOLD);
      if (load_s) begin
        val0_r      <= bcd2_to_bin(digit_s[1], digit_s[0]);
        val1_r      <= bcd2_to_bin(digit_s[3], digit_s[2]);
        val2_r      <= bcd2_to_bin(digit_s[5], digit_s[4]);
        blank_r     <= all_blank_s;
        err_r       <= err_s;
        have_last_r <= 1'b1;
        last_r      <= snap_r;
      end else begin
        have_last_r <= have_last_r;
        last_r      <= last_r;
      end
      if (drop_s) ovf_r <= 1'b1;
      else        ovf_r <= ovf_r;
    end
  end

  assign to_valid = valid_r;
  assign to_val0  = val0_r;
  assign to_val1  = val1_r;
  assign to_val2  = val2_r;
  assign to_blank = blank_r;
  assign to_err   = err_r;
  assign to_ovf   = ovf_r;

endmodule

// File: tb/tb_hex_frame_reader.sv
// Directed bench for hex_frame_reader: a table of decode vectors plus
// hand-written handshake, glitch, back-pressure and reset sequences.
module tb_hex_frame_reader;

  localparam int S = 4;

  logic        CK50M = 1'b0;
  logic        RST_N;
  logic [47:0] hex;
  logic        fr_ready;
  logic        to_valid, to_blank, to_err, to_ovf;
  logic [6:0]  to_val0, to_val1, to_val2;

  int checks = 0;
  int errors = 0;

  hex_frame_reader #(.STABLE_CYC(S), .CW(8)) dut (
    .CK50M(CK50M), .RST_N(RST_N),
    .fr_HEX0(hex[7:0]),   .fr_HEX1(hex[15:8]),  .fr_HEX2(hex[23:16]),
    .fr_HEX3(hex[31:24]), .fr_HEX4(hex[39:32]), .fr_HEX5(hex[47:40]),
    .fr_ready(fr_ready), .to_valid(to_valid),
    .to_val0(to_val0), .to_val1(to_val1), .to_val2(to_val2),
    .to_blank(to_blank), .to_err(to_err), .to_ovf(to_ovf)
  );

  always #5 CK50M = ~CK50M;

  typedef struct {
    logic [47:0] frame;
    logic [6:0]  v2, v1, v0;
    logic        blank, err;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [47:0] mk(input logic [7:0] h5, h4, h3, h2, h1, h0);
    return {h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK50M);
    #1;
  endtask

  // Counts edges until to_valid is seen; 99 means it never came.
  task automatic wait_valid(output int k);
    k = 99;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (to_valid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic take();
    fr_ready = 1'b1;
    tick();
    fr_ready = 1'b0;
    chk("valid_low_after_take", to_valid, 0);
  endtask

  initial begin
    int k;
    logic saw;
    vecs[0] = '{mk(8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82), 7'd12, 7'd34, 7'd56, 1'b0, 1'b0};
    vecs[1] = '{mk(8'h90, 8'h90, 8'h80, 8'hF8, 8'hC0, 8'hF9), 7'd99, 7'd87, 7'd1,  1'b0, 1'b0};
    vecs[2] = '{mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF), 7'd0,  7'd0,  7'd0,  1'b1, 1'b0};
    vecs[3] = '{mk(8'hF9, 8'hA4, 8'h7F, 8'h99, 8'h92, 8'h82), 7'd12, 7'd4,  7'd56, 1'b0, 1'b1};
    vecs[4] = '{mk(8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0), 7'd1,  7'd0,  7'd0,  1'b0, 1'b1};
    vecs[5] = '{mk(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h40), 7'd0,  7'd0,  7'd0,  1'b0, 1'b1};

    RST_N = 1'b0;
    fr_ready = 1'b0;
    hex = {6{8'hFF}};
    #12;
    chk("rst_valid", to_valid, 0);
    chk("rst_val0", to_val0, 0);
    chk("rst_ovf", to_ovf, 0);

    // Basic handshake
    tick();
    RST_N = 1'b1;
    hex = {6{8'hC0}};
    wait_valid(k);
    chk("basic_latency", k, S + 1);
    chk("basic_val0", to_val0, 0);
    chk("basic_err", to_err, 0);
    repeat (10) tick();
    chk("basic_hold_valid", to_valid, 1);
    chk("basic_hold_val2", to_val2, 0);
    take();

    // Decode table
    for (int i = 0; i < 6; i++) begin
      hex = vecs[i].frame;
      wait_valid(k);
      chk($sformatf("vec%0d_latency", i), k, S + 1);
      chk($sformatf("vec%0d_val2", i), to_val2, vecs[i].v2);
      chk($sformatf("vec%0d_val1", i), to_val1, vecs[i].v1);
      chk($sformatf("vec%0d_val0", i), to_val0, vecs[i].v0);
      chk($sformatf("vec%0d_blank", i), to_blank, vecs[i].blank);
      chk($sformatf("vec%0d_err", i), to_err, vecs[i].err);
      take();
    end

    // Glitch rejection from an accepted 12:34:56
    hex = vecs[0].frame;
    wait_valid(k);
    take();
    saw = 1'b0;
    hex[7:0] = 8'hF8;
    repeat (2) begin tick(); saw = saw | to_valid; end
    hex[7:0] = 8'h82;
    repeat (15) begin tick(); saw = saw | to_valid; end
    chk("glitch_no_valid", saw, 0);
    hex[7:0] = 8'hF8;
    wait_valid(k);
    chk("glitch_held_latency", k, S + 1);
    chk("glitch_held_val0", to_val0, 57);
    take();

    // Back-pressure: A held, B dropped, C reloaded on the taking edge
    hex = {6{8'h99}};
    wait_valid(k);
    chk("bp_a_val0", to_val0, 44);
    hex = {6{8'h92}};
    repeat (8) tick();
    chk("bp_b_valid", to_valid, 1);
    chk("bp_b_val0_held", to_val0, 44);
    chk("bp_ovf", to_ovf, 1);
    hex = {6{8'h82}};
    repeat (S) tick();
    fr_ready = 1'b1;
    tick();
    fr_ready = 1'b0;
    chk("bp_c_valid", to_valid, 1);
    chk("bp_c_val0", to_val0, 66);
    chk("bp_c_ovf_sticky", to_ovf, 1);
    take();

    // Reset while holding a frame
    hex = {6{8'hF9}};
    wait_valid(k);
    chk("rst_mid_pre_valid", to_valid, 1);
    #3;
    RST_N = 1'b0;
    #1;
    chk("rst_mid_valid", to_valid, 0);
    chk("rst_mid_val0", to_val0, 0);
    chk("rst_mid_ovf", to_ovf, 0);
    tick();
    tick();
    RST_N = 1'b1;
    wait_valid(k);
    chk("rst_rereport_latency", k, S + 1);
    chk("rst_rereport_val1", to_val1, 11);
    chk("rst_rereport_ovf", to_ovf, 0);
    take();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
